// File: rtl/mbtrain_pkg.sv
// Shared MBTRAIN definitions: sideband codes and the selfcal_rx state encoding.
// SELFCAL_TIMEOUT_EN adds the TIMEOUT state to the encoding.
package mbtrain_pkg;

   localparam logic [3:0] SB_NONE             = 4'b0000;
   localparam logic [3:0] SB_SELFCAL_END_REQ  = 4'b0001;
   localparam logic [3:0] SB_SELFCAL_END_RESP = 4'b0010;

   typedef enum logic [2:0] {
      SC_IDLE          = 3'd0,
      SC_LOCAL_CAL     = 3'd1,
      SC_WAIT_REQ      = 3'd2,
      SC_SEND_RESP     = 3'd3,
`ifdef SELFCAL_TIMEOUT_EN
      SC_TEST_FINISHED = 3'd4,
      SC_TIMEOUT       = 3'd5
`else
      SC_TEST_FINISHED = 3'd4
`endif
   } selfcal_rx_state_e;

endpackage

// File: rtl/selfcal_cal_timer.sv
// Clear/enable up-counter with a terminal-count flag.
// tc is high during the enabled cycle in which the count equals LIMIT-1,
// so the owning FSM can leave its state on that same edge.
module selfcal_cal_timer #(
   parameter int W     = 5,
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [W-1:0] cnt;

   // Counter: clear has priority over counting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt + 1'b1;
   end

   assign tc = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/selfcal_rx.sv
// MBTRAIN SELFCAL responder: local calibration, then answers the partner's
// end request with the end response through the shared sideband TX mux.
// Optional build macro SELFCAL_TIMEOUT_EN adds a WAIT_REQ timeout.
module selfcal_rx
   import mbtrain_pkg::*;
#(
   parameter int CAL_CYCLES     = 16,
   parameter int CAL_CNT_W      = 5,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int TO_CNT_W       = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_en,
   input  logic       i_sideband_valid,
   input  logic [3:0] i_decoded_sideband_message,
   input  logic       i_busy_negedge_detected,
   input  logic       i_valid_tx_peer,
   output logic [3:0] o_sideband_message,
   output logic       o_valid_tx,
   output logic       o_cal_done,
   output logic       o_test_ack,
   output logic       o_timeout
);

   selfcal_rx_state_e state, state_nx;
   logic       req_pending, pend_nx;
   logic [3:0] msg_nx;
   logic       valid_nx, done_nx, ack_nx;
   logic       req, cal_tc;

   assign req = i_sideband_valid && (i_decoded_sideband_message == SB_SELFCAL_END_REQ);

   selfcal_cal_timer #(.W(CAL_CNT_W), .LIMIT(CAL_CYCLES)) u_cal_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state != SC_LOCAL_CAL),
      .en    (state == SC_LOCAL_CAL),
      .tc    (cal_tc)
   );

`ifdef SELFCAL_TIMEOUT_EN
   logic to_tc, to_nx;

   selfcal_cal_timer #(.W(TO_CNT_W), .LIMIT(TIMEOUT_CYCLES)) u_to_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state != SC_WAIT_REQ),
      .en    (state == SC_WAIT_REQ),
      .tc    (to_tc)
   );

   // Timeout flag register, held until the sequencer drops i_en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) o_timeout <= 1'b0;
      else        o_timeout <= to_nx;
   end
`else
   assign o_timeout = 1'b0;
`endif

   // State, pending request and all outputs are registered together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= SC_IDLE;
         req_pending        <= 1'b0;
         o_sideband_message <= SB_NONE;
         o_valid_tx         <= 1'b0;
         o_cal_done         <= 1'b0;
         o_test_ack         <= 1'b0;
      end else begin
         state              <= state_nx;
         req_pending        <= pend_nx;
         o_sideband_message <= msg_nx;
         o_valid_tx         <= valid_nx;
         o_cal_done         <= done_nx;
         o_test_ack         <= ack_nx;
      end
   end

   // Next state and next registered outputs; dropping i_en overrides everything.
   always_comb begin
      state_nx = state;
      pend_nx  = req_pending;
      msg_nx   = o_sideband_message;
      valid_nx = o_valid_tx;
      done_nx  = o_cal_done;
      ack_nx   = o_test_ack;
`ifdef SELFCAL_TIMEOUT_EN
      to_nx    = o_timeout;
`endif
      if (!i_en) begin
         state_nx = SC_IDLE;
         pend_nx  = 1'b0;
         msg_nx   = SB_NONE;
         valid_nx = 1'b0;
         done_nx  = 1'b0;
         ack_nx   = 1'b0;
`ifdef SELFCAL_TIMEOUT_EN
         to_nx    = 1'b0;
`endif
      end else begin
         case (state)
            SC_IDLE: state_nx = SC_LOCAL_CAL;
            SC_LOCAL_CAL: begin
               if (req) pend_nx = 1'b1;
               if (cal_tc) begin
                  done_nx = 1'b1;
                  pend_nx = 1'b0;
                  if (req_pending || req) begin
                     state_nx = SC_SEND_RESP;
                     msg_nx   = SB_SELFCAL_END_RESP;
                     valid_nx = 1'b1;
                  end else begin
                     state_nx = SC_WAIT_REQ;
                  end
               end
            end
            SC_WAIT_REQ: begin
               if (req) begin
                  state_nx = SC_SEND_RESP;
                  msg_nx   = SB_SELFCAL_END_RESP;
                  valid_nx = 1'b1;
               end
`ifdef SELFCAL_TIMEOUT_EN
               else if (to_tc) begin
                  state_nx = SC_TIMEOUT;
                  to_nx    = 1'b1;
               end
`endif
            end
            SC_SEND_RESP: begin
               // A busy pulse belonging to the peer's message is not ours.
               if (i_busy_negedge_detected && !i_valid_tx_peer) begin
                  state_nx = SC_TEST_FINISHED;
                  msg_nx   = SB_NONE;
                  valid_nx = 1'b0;
                  ack_nx   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
